// File: rtl/bcd_count_pkg.sv
// Shared types and constants for the two-digit BCD counter and its
// seven-segment decoders. Segment vectors are indexed [1:7] so that
// bit 1 is segment a and bit 7 is segment g; all patterns are active-low.
package bcd_count_pkg;

  // One decimal digit in BCD; only 0..9 are meaningful.
  typedef logic [3:0] bcd_t;

  // Active-low segments a..g, bit 1 = a, bit 7 = g.
  typedef logic [1:7] seg_t;

  localparam bcd_t BCD_ZERO = 4'd0;
  localparam bcd_t BCD_NINE = 4'd9;

  localparam seg_t SEG_0     = 7'b0000001;
  localparam seg_t SEG_1     = 7'b1001111;
  localparam seg_t SEG_2     = 7'b0010010;
  localparam seg_t SEG_3     = 7'b0000110;
  localparam seg_t SEG_4     = 7'b1001100;
  localparam seg_t SEG_5     = 7'b0100100;
  localparam seg_t SEG_6     = 7'b0100000;
  localparam seg_t SEG_7     = 7'b0001111;
  localparam seg_t SEG_8     = 7'b0000000;
  localparam seg_t SEG_9     = 7'b0000100;
  localparam seg_t SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg7_decoder.sv
// BCD digit to active-low seven-segment decoder. Purely combinational;
// non-decimal codes 10..15 blank the display.
module seg7_decoder
  import bcd_count_pkg::*;
(
  input  bcd_t bcd,
  output seg_t seg
);

  // Map each digit to its segment pattern.
  always_comb begin
    // NOTE: default assignment first so every path drives seg and no latch is inferred.
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/bcd_count.sv
// Two-digit BCD up-counter (00..99) advanced by a free-running prescaler
// tick, with seven-segment outputs for both digits.
// DIV sets the clock cycles per count step (legal 2..2^24).
// Optional build macro BCD_SATURATE_EN: when defined, the count holds at
// 99 and ovf becomes sticky until reset; otherwise the count wraps to 00
// and ovf pulses for the single cycle following the wrap.
module bcd_count
  import bcd_count_pkg::*;
#(
  parameter int unsigned DIV = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output bcd_t bcd1,
  output bcd_t bcd0,
  output seg_t seg1,
  output seg_t seg0,
  output logic ovf
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] TICK_AT = PW'(DIV - 1);

  logic [PW-1:0] presc;
  logic          tick;
  logic          step;
  logic          at_max;

  // tick is a clock enable on the single clock domain, never a clock.
  assign tick   = (presc == TICK_AT);
  assign step   = tick && en;
  assign at_max = (bcd1 == BCD_NINE) && (bcd0 == BCD_NINE);

  // Prescaler: free-running 0..DIV-1, independent of en.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      presc <= '0;
    end else if (tick) begin
      presc <= '0;
    end else begin
      presc <= presc + PW'(1);
    end
  end

  // Decimal counter and overflow flag, updated on the prescaler wrap edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bcd1 <= BCD_ZERO;
      bcd0 <= BCD_ZERO;
      ovf  <= 1'b0;
    end else begin
`ifdef BCD_SATURATE_EN
      if (step) begin
        if (at_max) begin
          ovf <= 1'b1;
        end else if (bcd0 == BCD_NINE) begin
          bcd0 <= BCD_ZERO;
          bcd1 <= bcd1 + 4'd1;
        end else begin
          bcd0 <= bcd0 + 4'd1;
        end
      end
`else
      // ovf is high only for the cycle after the 99 -> 00 wrap.
      ovf <= step && at_max;
      if (step) begin
        if (at_max) begin
          bcd1 <= BCD_ZERO;
          bcd0 <= BCD_ZERO;
        end else if (bcd0 == BCD_NINE) begin
          bcd0 <= BCD_ZERO;
          bcd1 <= bcd1 + 4'd1;
        end else begin
          bcd0 <= bcd0 + 4'd1;
        end
      end
`endif
    end
  end

  seg7_decoder u_seg1 (
    .bcd (bcd1),
    .seg (seg1)
  );

  seg7_decoder u_seg0 (
    .bcd (bcd0),
    .seg (seg0)
  );

endmodule

// File: tb/tb_bcd_count.sv
// Scoreboard bench for bcd_count with DIV=4. Stimulus pushes expected
// values into a queue once outputs have settled; an independent monitor
// pops each entry and compares it against the live DUT outputs.
// A standalone seg7_decoder is swept over all 16 input codes.
module tb_bcd_count;

  localparam int unsigned DIV = 4;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] bcd1;
  logic [3:0] bcd0;
  logic [1:7] seg1;
  logic [1:7] seg0;
  logic       ovf;

  logic [3:0] dec_in;
  logic [1:7] dec_seg;

  int errors;
  int checks;

  typedef struct {
    string      name;
    bit         is_dec;
    logic [3:0] b1;
    logic [3:0] b0;
    logic [6:0] s1;
    logic [6:0] s0;
    logic       ov;
  } exp_t;

  exp_t sb[$];

  bcd_count #(.DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .en   (en),
    .bcd1 (bcd1),
    .bcd0 (bcd0),
    .seg1 (seg1),
    .seg0 (seg0),
    .ovf  (ovf)
  );

  seg7_decoder u_dec (
    .bcd (dec_in),
    .seg (dec_seg)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hand-written segment table, active-low abcdefg.
  function automatic logic [6:0] seg_exp(input int d);
    case (d)
      0:       return 7'b0000001;
      1:       return 7'b1001111;
      2:       return 7'b0010010;
      3:       return 7'b0000110;
      4:       return 7'b1001100;
      5:       return 7'b0100100;
      6:       return 7'b0100000;
      7:       return 7'b0001111;
      8:       return 7'b0000000;
      9:       return 7'b0000100;
      default: return 7'b1111111;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act[6:0], exp[6:0]);
    end
  endtask

  task automatic expect_top(input string name, input int d1, input int d0, input logic ov);
    exp_t e;
    e.name   = name;
    e.is_dec = 1'b0;
    e.b1     = 4'(d1);
    e.b0     = 4'(d0);
    e.s1     = seg_exp(d1);
    e.s0     = seg_exp(d0);
    e.ov     = ov;
    sb.push_back(e);
    #1;
  endtask

  task automatic expect_dec(input int v);
    exp_t e;
    e.name   = $sformatf("dec%0d", v);
    e.is_dec = 1'b1;
    e.b1     = 4'd0;
    e.b0     = 4'(v);
    e.s1     = 7'b0;
    e.s0     = seg_exp(v);
    e.ov     = 1'b0;
    sb.push_back(e);
    #1;
  endtask

  // Monitor: compares each queued expectation with the DUT outputs.
  initial begin
    exp_t e;
    forever begin
      wait (sb.size() != 0);
      e = sb.pop_front();
      if (e.is_dec) begin
        check({e.name, ".seg"}, 32'(dec_seg), 32'(e.s0));
      end else begin
        check({e.name, ".bcd1"}, 32'(bcd1), 32'(e.b1));
        check({e.name, ".bcd0"}, 32'(bcd0), 32'(e.b0));
        check({e.name, ".seg1"}, 32'(seg1), 32'(e.s1));
        check({e.name, ".seg0"}, 32'(seg0), 32'(e.s0));
        check({e.name, ".ovf"},  32'(ovf),  32'(e.ov));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic async_reset_pulse(input string name);
    @(posedge clk);
    #2 rst = 1'b1;
    #1 expect_top(name, 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    en     = 1'b0;
    dec_in = 4'd0;

    #1 expect_top("por", 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b1;

    // Two ticks, then an asynchronous reset between clock edges.
    repeat (8) @(posedge clk);
    @(negedge clk);
    expect_top("pre_rst", 0, 2, 1'b0);
    async_reset_pulse("async_rst");

    // 40 cycles -> ten ticks -> count 10.
    repeat (40) @(posedge clk);
    @(negedge clk);
    expect_top("count10", 1, 0, 1'b0);

    // Hold at 07 across three ticks with en low, then resume.
    async_reset_pulse("rst_hold");
    repeat (28) @(posedge clk);
    @(negedge clk);
    expect_top("at07", 0, 7, 1'b0);
    en = 1'b0;
    repeat (12) @(posedge clk);
    @(negedge clk);
    expect_top("hold07", 0, 7, 1'b0);
    en = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    expect_top("resume08", 0, 8, 1'b0);

    // Approach and cross the 99 boundary.
    repeat (360) @(posedge clk);
    @(negedge clk);
    expect_top("at98", 9, 8, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    expect_top("at99", 9, 9, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_top("pre_tick99", 9, 9, 1'b0);
    repeat (1) @(posedge clk);
    @(negedge clk);
`ifdef BCD_SATURATE_EN
    expect_top("sat_hit", 9, 9, 1'b1);
    repeat (1) @(posedge clk);
    @(negedge clk);
    expect_top("sat_sticky1", 9, 9, 1'b1);
    repeat (4) @(posedge clk);
    @(negedge clk);
    expect_top("sat_sticky2", 9, 9, 1'b1);
`else
    expect_top("wrap_hit", 0, 0, 1'b1);
    repeat (1) @(posedge clk);
    @(negedge clk);
    expect_top("wrap_pulse_end", 0, 0, 1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    expect_top("wrap_next", 0, 1, 1'b0);
`endif

    // Mid-count reset at 42 with the prescaler at 2.
    async_reset_pulse("rst_mid");
    repeat (170) @(posedge clk);
    @(negedge clk);
    expect_top("at42", 4, 2, 1'b0);
    rst = 1'b1;
    #1 expect_top("mid_rst", 0, 0, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    expect_top("rel_plus3", 0, 0, 1'b0);
    repeat (1) @(posedge clk);
    @(negedge clk);
    expect_top("rel_plus4", 0, 1, 1'b0);

    // Exhaustive decoder sweep.
    for (int i = 0; i < 16; i++) begin
      dec_in = 4'(i);
      #1 expect_dec(i);
    end

    // Let the monitor drain, bounded.
    for (int k = 0; k < 100 && sb.size() != 0; k++) #1;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
